// File: rtl/mem_write_checker.sv
// mem_write_checker: snoops the data-memory write port of the core and checks
// the stream of writes against a loaded table of expected (address, data) words.
// Optional feature macro CHK_UNORDERED_EN: when defined, a write may match any
// not-yet-matched table entry; when undefined, entries must be written in order.
module mem_write_checker #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 300
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clr,
    input  logic                         exp_valid,
    output logic                         exp_ready,
    input  logic [ADDR_W-1:0]            exp_adr,
    input  logic [DATA_W-1:0]            exp_data,
    input  logic                         start,
    input  logic                         MemWrite,
    input  logic [ADDR_W-1:0]            DataAdr,
    input  logic [DATA_W-1:0]            WriteData,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [$clog2(DEPTH+1)-1:0]   correct_cnt,
    output logic [7:0]                   error_cnt,
    output logic [ADDR_W-1:0]            last_bad_adr
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state, state_nx;
    logic [CW-1:0]       count, count_nx;
    logic [TW-1:0]       timer, timer_nx;
    logic [CW-1:0]       correct_nx;
    logic [7:0]          error_nx;
    logic [ADDR_W-1:0]   bad_nx;
    logic                pass_nx;
    logic                ready_nx;
    logic                push;
    logic                begin_run;
    logic                is_hit;

    logic [ADDR_W-1:0]   tab_adr  [DEPTH];
    logic [DATA_W-1:0]   tab_data [DEPTH];

`ifdef CHK_UNORDERED_EN
    logic [DEPTH-1:0]    hit_vec, hit_vec_nx, hit_set;
`else
    logic [IW-1:0]       ptr;
    assign ptr = correct_cnt[IW-1:0];
`endif

    // Decide whether the snooped write matches the table (lowest free entry wins when unordered)
    always_comb begin
        is_hit = 1'b0;
`ifdef CHK_UNORDERED_EN
        hit_set = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!is_hit && (CW'(i) < count) && !hit_vec[i] &&
                (tab_adr[i] == DataAdr) && (tab_data[i] == WriteData)) begin
                is_hit     = 1'b1;
                hit_set[i] = 1'b1;
            end
        end
`else
        if ((correct_cnt < count) && (tab_adr[ptr] == DataAdr) && (tab_data[ptr] == WriteData)) begin
            is_hit = 1'b1;
        end
`endif
    end

    // Next-state and next-counter logic; clr has priority over start and pushes
    always_comb begin
        state_nx   = state;
        count_nx   = count;
        timer_nx   = timer;
        correct_nx = correct_cnt;
        error_nx   = error_cnt;
        bad_nx     = last_bad_adr;
        pass_nx    = pass;
        push       = 1'b0;
        begin_run  = 1'b0;
`ifdef CHK_UNORDERED_EN
        hit_vec_nx = hit_vec;
`endif
        case (state)
            IDLE: begin
                if (clr) begin
                    count_nx = '0;
                end else if (start) begin
                    begin_run = 1'b1;
                end else if (exp_valid && exp_ready) begin
                    push     = 1'b1;
                    count_nx = count + CW'(1);
                end
            end
            RUN: begin
                timer_nx = timer + TW'(1);
                if (MemWrite) begin
                    if (is_hit) begin
                        correct_nx = correct_cnt + CW'(1);
`ifdef CHK_UNORDERED_EN
                        hit_vec_nx = hit_vec | hit_set;
`endif
                    end else begin
                        error_nx = (error_cnt == 8'hFF) ? error_cnt : error_cnt + 8'd1;
                        bad_nx   = DataAdr;
                    end
                end
                if (correct_nx == count) begin
                    state_nx = DONE;
                    pass_nx  = (error_nx == 8'd0);
                end else if (timer_nx >= TW'(TIMEOUT - 1)) begin
                    state_nx = DONE;
                    pass_nx  = 1'b0;
                end
            end
            DONE: begin
                if (clr) begin
                    count_nx = '0;
                    state_nx = IDLE;
                    pass_nx  = 1'b0;
                end else if (start) begin
                    begin_run = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (begin_run) begin
            state_nx   = RUN;
            timer_nx   = '0;
            correct_nx = '0;
            error_nx   = 8'd0;
            bad_nx     = '0;
            pass_nx    = 1'b0;
`ifdef CHK_UNORDERED_EN
            hit_vec_nx = '0;
`endif
        end
        ready_nx = (state_nx == IDLE) && (count_nx < CW'(DEPTH));
    end

    // State, counters and registered status outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            count        <= '0;
            timer        <= '0;
            correct_cnt  <= '0;
            error_cnt    <= 8'd0;
            last_bad_adr <= '0;
            pass         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            exp_ready    <= 1'b1;
`ifdef CHK_UNORDERED_EN
            hit_vec      <= '0;
`endif
        end else begin
            state        <= state_nx;
            count        <= count_nx;
            timer        <= timer_nx;
            correct_cnt  <= correct_nx;
            error_cnt    <= error_nx;
            last_bad_adr <= bad_nx;
            pass         <= pass_nx;
            busy         <= (state_nx == RUN);
            done         <= (state_nx == DONE);
            exp_ready    <= ready_nx;
`ifdef CHK_UNORDERED_EN
            hit_vec      <= hit_vec_nx;
`endif
        end
    end

    // Expected-entry storage; contents past count are don't-care so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            tab_adr[count[IW-1:0]]  <= exp_adr;
            tab_data[count[IW-1:0]] <= exp_data;
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// tb_mem_write_checker: directed bench for mem_write_checker with a queue-based
// reference model compared every cycle plus hand-computed literal expectations.
module tb_mem_write_checker;

    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       exp_valid = 1'b0;
    logic       exp_ready;
    logic [7:0] exp_adr = 8'd0;
    logic [7:0] exp_data = 8'd0;
    logic       start = 1'b0;
    logic       MemWrite = 1'b0;
    logic [7:0] DataAdr = 8'd0;
    logic [7:0] WriteData = 8'd0;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] correct_cnt;
    logic [7:0] error_cnt;
    logic [7:0] last_bad_adr;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] d;
    } entry_t;

    entry_t tbl[$];
    bit     used[DEPTH];
    bit     m_busy = 1'b0;
    bit     m_done = 1'b0;
    bit     m_pass = 1'b0;
    int     m_cc = 0;
    int     m_ec = 0;
    int     m_bad = 0;
    int     m_cyc = 0;

    mem_write_checker #(
        .DATA_W(8), .ADDR_W(8), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset), .clr(clr),
        .exp_valid(exp_valid), .exp_ready(exp_ready),
        .exp_adr(exp_adr), .exp_data(exp_data),
        .start(start), .MemWrite(MemWrite),
        .DataAdr(DataAdr), .WriteData(WriteData),
        .busy(busy), .done(done), .pass(pass),
        .correct_cnt(correct_cnt), .error_cnt(error_cnt),
        .last_bad_adr(last_bad_adr)
    );

    // Free-running clock, period 10
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs, then return them to idle at the next falling edge
    task automatic applyStimulus(input logic p, input logic w, input logic s, input logic c,
                                 input logic [7:0] a, input logic [7:0] d);
        exp_valid = p; MemWrite = w; start = s; clr = c;
        exp_adr = a; exp_data = d; DataAdr = a; WriteData = d;
        @(negedge clk);
        exp_valid = 1'b0; MemWrite = 1'b0; start = 1'b0; clr = 1'b0;
    endtask

    // Reference model: table is a queue, run outcome follows the matching rules directly
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                tbl.delete();
                m_busy = 0; m_done = 0; m_pass = 0;
                m_cc = 0; m_ec = 0; m_bad = 0; m_cyc = 0;
            end else if (!m_busy) begin
                if (clr) begin
                    tbl.delete();
                    m_done = 0; m_pass = 0;
                end else if (start) begin
                    m_busy = 1; m_done = 0; m_pass = 0;
                    m_cc = 0; m_ec = 0; m_bad = 0; m_cyc = 0;
                    foreach (used[j]) used[j] = 0;
                end else if (!m_done && exp_valid && tbl.size() < DEPTH) begin
                    tbl.push_back('{exp_adr, exp_data});
                end
            end else begin
                m_cyc++;
                if (MemWrite) begin
                    bit hit;
                    hit = 0;
`ifdef CHK_UNORDERED_EN
                    for (int j = 0; j < tbl.size(); j++) begin
                        if (!hit && !used[j] && tbl[j].a == DataAdr && tbl[j].d == WriteData) begin
                            hit = 1;
                            used[j] = 1;
                        end
                    end
`else
                    if (m_cc < tbl.size() && tbl[m_cc].a == DataAdr && tbl[m_cc].d == WriteData) hit = 1;
`endif
                    if (hit) m_cc++;
                    else begin
                        if (m_ec < 255) m_ec++;
                        m_bad = DataAdr;
                    end
                end
                if (m_cc == tbl.size()) begin
                    m_busy = 0; m_done = 1; m_pass = (m_ec == 0);
                end else if (m_cyc >= TIMEOUT - 1) begin
                    m_busy = 0; m_done = 1; m_pass = 0;
                end
            end
        end
    end

    // Compare DUT against the model on every falling edge
    always @(negedge clk) begin
        if (chk_en) begin
            checkOutput("busy", busy, m_busy);
            checkOutput("done", done, m_done);
            checkOutput("exp_ready", exp_ready, (!m_busy && !m_done && tbl.size() < DEPTH));
            checkOutput("correct_cnt", correct_cnt, m_cc);
            checkOutput("error_cnt", error_cnt, m_ec);
            checkOutput("last_bad_adr", last_bad_adr, m_bad);
            if (m_done) checkOutput("pass", pass, m_pass);
        end
    end

    // Directed test sequence
    initial begin
        int n;
        #1 reset = 1'b1;
        #1 chk_en = 1'b1;
        #19 reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_ready", exp_ready, 1);
        checkOutput("rst_err", error_cnt, 0);

        // Test 1: in-order writes of the loaded table
        applyStimulus(1, 0, 0, 0, 8'd1, 8'd67);
        applyStimulus(1, 0, 0, 0, 8'd2, 8'd65);
        applyStimulus(1, 0, 0, 0, 8'd3, 8'd83);
        applyStimulus(1, 0, 0, 0, 8'd4, 8'd65);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        checkOutput("t1_busy", busy, 1);
        applyStimulus(0, 1, 0, 0, 8'd1, 8'd67);
        applyStimulus(0, 1, 0, 0, 8'd2, 8'd65);
        applyStimulus(0, 1, 0, 0, 8'd3, 8'd83);
        checkOutput("t1_notdone", done, 0);
        applyStimulus(0, 1, 0, 0, 8'd4, 8'd65);
        checkOutput("t1_done", done, 1);
        checkOutput("t1_pass", pass, 1);
        checkOutput("t1_cc", correct_cnt, 4);
        checkOutput("t1_ec", error_cnt, 0);
        applyStimulus(0, 0, 0, 1, 8'd0, 8'd0);
        checkOutput("t1_clr_idle", done, 0);

        // Test 2: one extra bad write mid-run
        applyStimulus(1, 0, 0, 0, 8'd9,  8'd76);
        applyStimulus(1, 0, 0, 0, 8'd10, 8'd73);
        applyStimulus(1, 0, 0, 0, 8'd11, 8'd66);
        applyStimulus(1, 0, 0, 0, 8'd12, 8'd82);
        applyStimulus(1, 0, 0, 0, 8'd13, 8'd79);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 0, 0, 8'd9,  8'd76);
        applyStimulus(0, 1, 0, 0, 8'd10, 8'd74);
        applyStimulus(0, 1, 0, 0, 8'd10, 8'd73);
        applyStimulus(0, 1, 0, 0, 8'd11, 8'd66);
        applyStimulus(0, 1, 0, 0, 8'd12, 8'd82);
        applyStimulus(0, 1, 0, 0, 8'd13, 8'd79);
        checkOutput("t2_done", done, 1);
        checkOutput("t2_pass", pass, 0);
        checkOutput("t2_ec", error_cnt, 1);
        checkOutput("t2_bad", last_bad_adr, 10);
        applyStimulus(0, 0, 0, 1, 8'd0, 8'd0);

        // Test 3: only one of two entries written, run ends on timeout
        applyStimulus(1, 0, 0, 0, 8'd20, 8'd1);
        applyStimulus(1, 0, 0, 0, 8'd21, 8'd2);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 0, 0, 8'd20, 8'd1);
        n = 1;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t3_latency", n, 299);
        checkOutput("t3_pass", pass, 0);
        checkOutput("t3_cc", correct_cnt, 1);
        applyStimulus(0, 0, 0, 1, 8'd0, 8'd0);

        // Test 4: overfill the table, last push must be dropped
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) checkOutput("t4_ready_before_full", exp_ready, 1);
            applyStimulus(1, 0, 0, 0, 8'(100 + i), 8'(3 * i));
        end
        checkOutput("t4_ready_full", exp_ready, 0);
        applyStimulus(1, 0, 0, 0, 8'd108, 8'd24);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 1, 0, 0, 8'(100 + i), 8'(3 * i));
        checkOutput("t4_done", done, 1);
        checkOutput("t4_pass", pass, 1);
        checkOutput("t4_cc", correct_cnt, 8);
        applyStimulus(0, 0, 0, 1, 8'd0, 8'd0);

        // Test 5: test-1 table written in reverse order
        applyStimulus(1, 0, 0, 0, 8'd1, 8'd67);
        applyStimulus(1, 0, 0, 0, 8'd2, 8'd65);
        applyStimulus(1, 0, 0, 0, 8'd3, 8'd83);
        applyStimulus(1, 0, 0, 0, 8'd4, 8'd65);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 0, 0, 8'd4, 8'd65);
        applyStimulus(0, 1, 0, 0, 8'd3, 8'd83);
        applyStimulus(0, 1, 0, 0, 8'd2, 8'd65);
        applyStimulus(0, 1, 0, 0, 8'd1, 8'd67);
        n = 0;
        while (!done && n < 400) begin
            @(negedge clk);
            n++;
        end
        checkOutput("t5_done", done, 1);
`ifdef CHK_UNORDERED_EN
        checkOutput("t5_pass", pass, 1);
        checkOutput("t5_ec", error_cnt, 0);
`else
        checkOutput("t5_pass", pass, 0);
        checkOutput("t5_ec", error_cnt, 3);
        checkOutput("t5_cc", correct_cnt, 1);
`endif
        applyStimulus(0, 0, 0, 1, 8'd0, 8'd0);

        // Test 6: reset mid-run, then an empty-table run
        applyStimulus(1, 0, 0, 0, 8'd30, 8'd5);
        applyStimulus(1, 0, 0, 0, 8'd31, 8'd6);
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        applyStimulus(0, 1, 0, 0, 8'd30, 8'd5);
        checkOutput("t6_cc_pre", correct_cnt, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("t6_busy", busy, 0);
        checkOutput("t6_done", done, 0);
        checkOutput("t6_cc", correct_cnt, 0);
        checkOutput("t6_ready", exp_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 1, 0, 8'd0, 8'd0);
        checkOutput("t6_run1", busy, 1);
        @(negedge clk);
        checkOutput("t6_empty_done", done, 1);
        checkOutput("t6_empty_pass", pass, 1);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
